// File: rtl/dual_issue_scheduler.sv
// Issue-stage scheduler: holds one decoded pair (A older, B younger),
// issues in order to even/odd pipes under a RAW latency scoreboard.
// Ports: clk/reset, in_* decoded pair + valid/ready, branch_taken flush,
// iss_even_*/iss_odd_* strobes and slot selects, iss_first_odd, stall_raw.
// Optional SCHED_STALL_CNT_EN adds cnt_raw_stall / cnt_single_issue.
module dual_issue_scheduler #(
  parameter int NREG  = 128,
  parameter int LAT_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_vld_a,
  input  logic             in_vld_b,
  input  logic             in_odd_a,
  input  logic             in_odd_b,
  input  logic [6:0]       in_rt_a,
  input  logic [6:0]       in_rt_b,
  input  logic             in_wr_a,
  input  logic             in_wr_b,
  input  logic [LAT_W-1:0] in_lat_a,
  input  logic [LAT_W-1:0] in_lat_b,
  input  logic [20:0]      in_src_a,
  input  logic [20:0]      in_src_b,
  input  logic [2:0]       in_use_a,
  input  logic [2:0]       in_use_b,
  input  logic             branch_taken,
  output logic             iss_even_vld,
  output logic             iss_even_slot,
  output logic             iss_odd_vld,
  output logic             iss_odd_slot,
  output logic             iss_first_odd,
  output logic             stall_raw
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_raw_stall,
  output logic [CNT_W-1:0] cnt_single_issue
`endif
);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] PEND_AB = 2'd1;
  localparam logic [1:0] PEND_A  = 2'd2;
  localparam logic [1:0] PEND_B  = 2'd3;

  logic [1:0]       state;
  logic             a_odd, b_odd, a_wr, b_wr;
  logic [6:0]       a_rt, b_rt;
  logic [LAT_W-1:0] a_lat, b_lat;
  logic [20:0]      a_src, b_src;
  logic [2:0]       a_use, b_use;
  logic [LAT_W-1:0] sb [NREG];

  logic a_pend, b_pend, rdy_a, rdy_b, dep;
  logic iss_a, iss_b, all_done, accept;

  always_comb begin
    a_pend = (state == PEND_AB) | (state == PEND_A);
    b_pend = (state == PEND_AB) | (state == PEND_B);
    rdy_a = (!a_use[2] | (sb[a_src[20:14]] == '0))
          & (!a_use[1] | (sb[a_src[13:7]] == '0))
          & (!a_use[0] | (sb[a_src[6:0]] == '0));
    rdy_b = (!b_use[2] | (sb[b_src[20:14]] == '0))
          & (!b_use[1] | (sb[b_src[13:7]] == '0))
          & (!b_use[0] | (sb[b_src[6:0]] == '0));
    // B must not consume A's result in the cycle A issues
    dep = a_wr & ((b_use[2] & (b_src[20:14] == a_rt))
                | (b_use[1] & (b_src[13:7] == a_rt))
                | (b_use[0] & (b_src[6:0] == a_rt)));
    iss_a = !reset & !branch_taken & a_pend & rdy_a;
    iss_b = !reset & !branch_taken & rdy_b
          & ((state == PEND_B)
           | ((state == PEND_AB) & iss_a & (a_odd != b_odd) & !dep));
    unique case (state)
      PEND_AB: all_done = iss_a & iss_b;
      PEND_A:  all_done = iss_a;
      PEND_B:  all_done = iss_b;
      default: all_done = 1'b1;
    endcase
    in_ready = !reset & !branch_taken & all_done;
    accept   = in_valid & in_ready & in_vld_a;
    iss_even_vld  = (iss_a & !a_odd) | (iss_b & !b_odd);
    iss_even_slot = iss_b & !b_odd;
    iss_odd_vld   = (iss_a & a_odd) | (iss_b & b_odd);
    iss_odd_slot  = iss_b & b_odd;
    iss_first_odd = iss_a & a_odd;
    stall_raw = !reset & ((a_pend & !rdy_a) | (b_pend & !rdy_b));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else if (branch_taken) begin
      state <= EMPTY;
    end else if (accept) begin
      state <= in_vld_b ? PEND_AB : PEND_A;
    end else if (all_done) begin
      state <= EMPTY;
    end else if ((state == PEND_AB) & iss_a) begin
      state <= PEND_B;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_odd <= in_odd_a;
      a_wr  <= in_wr_a;
      a_rt  <= in_rt_a;
      a_lat <= in_lat_a;
      a_src <= in_src_a;
      a_use <= in_use_a;
      b_odd <= in_odd_b;
      b_wr  <= in_wr_b;
      b_rt  <= in_rt_b;
      b_lat <= in_lat_b;
      b_src <= in_src_b;
      b_use <= in_use_b;
    end
  end

  // B is checked first so it wins a same-rt collision with A
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) begin
        sb[r] <= '0;
      end else if (iss_b & b_wr & (b_lat != '0) & (b_rt == 7'(r))) begin
        sb[r] <= b_lat;
      end else if (iss_a & a_wr & (a_lat != '0) & (a_rt == 7'(r))) begin
        sb[r] <= a_lat;
      end else if (sb[r] != '0) begin
        sb[r] <= sb[r] - 1'b1;
      end
    end
  end

`ifdef SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_raw_stall    <= '0;
      cnt_single_issue <= '0;
    end else begin
      if (stall_raw)
        cnt_raw_stall <= cnt_raw_stall + 1'b1;
      if ((state == PEND_AB) & (iss_even_vld ^ iss_odd_vld))
        cnt_single_issue <= cnt_single_issue + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
